// File: rtl/screen_sequencer_if.sv
// Video-side bundle for the screen sequencer: raster position, sprite layers,
// user controls, and the composited pixel / sequence status coming back.
interface screen_sequencer_if #(
    parameter int NUM_SCREENS = 4,
    parameter int NUM_LAYERS  = 3,
    parameter int PIX_W       = 12
);
    localparam int SCR_W = (NUM_SCREENS > 1) ? $clog2(NUM_SCREENS) : 1;

    logic [10:0]                 hcount_in;
    logic [9:0]                  vcount_in;
    logic [NUM_LAYERS*PIX_W-1:0] layer_pix_in;
    logic [NUM_LAYERS-1:0]       layer_gate_in;
    logic                        arm_in;
    logic                        btn_in;
    logic                        auto_in;
    logic                        restart_in;
    logic [PIX_W-1:0]            pixel_out;
    logic [SCR_W-1:0]            screen_out;
    logic                        screen_done_out;
    logic                        seq_done_out;

    modport master (
        output hcount_in, vcount_in, layer_pix_in, layer_gate_in,
        output arm_in, btn_in, auto_in, restart_in,
        input  pixel_out, screen_out, screen_done_out, seq_done_out
    );

    modport slave (
        input  hcount_in, vcount_in, layer_pix_in, layer_gate_in,
        input  arm_in, btn_in, auto_in, restart_in,
        output pixel_out, screen_out, screen_done_out, seq_done_out
    );
endinterface

// File: rtl/screen_sequencer.sv
// Steps through a fixed list of screens, compositing sprite layers while a screen
// is shown and filling with a blank colour during transitions and once finished.
module screen_sequencer #(
    parameter int                              NUM_SCREENS    = 4,
    parameter int                              NUM_LAYERS     = 3,
    parameter int                              PIX_W          = 12,
    parameter logic [NUM_SCREENS*NUM_LAYERS-1:0] LAYER_MASK   = '1,
    parameter int                              TIMEOUT_FRAMES = 300,
    parameter int                              TRANS_FRAMES   = 2,
    parameter logic [PIX_W-1:0]                BLANK_COLOR    = 12'hFFF,
    parameter int                              H_ACTIVE       = 1024,
    parameter int                              V_ACTIVE       = 768
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    screen_sequencer_if.slave  bus
);
    localparam int SCR_W   = (NUM_SCREENS > 1) ? $clog2(NUM_SCREENS) : 1;
    localparam int CNT_TOP = (TIMEOUT_FRAMES > TRANS_FRAMES) ? TIMEOUT_FRAMES : TRANS_FRAMES;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
    localparam logic [CNT_W-1:0] TRANS_LAST   = CNT_W'(TRANS_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};
    localparam logic [SCR_W-1:0] LAST_SCREEN  = SCR_W'(NUM_SCREENS - 1);
    localparam logic [10:0]      H_LIM        = 11'(H_ACTIVE);
    localparam logic [9:0]       V_LIM        = 10'(V_ACTIVE);

    typedef enum logic [1:0] {
        ST_SHOW  = 2'd0,
        ST_TRANS = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state_r;
    logic [SCR_W-1:0]      screen_r;
    logic [CNT_W-1:0]      frame_cnt_r;
    logic [PIX_W-1:0]      pixel_r;
    logic                  screen_done_r;
    logic                  seq_done_r;

    logic                  frame_start_s;
    logic                  active_s;
    logic                  advance_s;
    logic [CNT_W-1:0]      cnt_inc_s;
    logic [NUM_LAYERS-1:0] scr_mask_s;
    logic [PIX_W-1:0]      comp_pix_s;
    logic [PIX_W-1:0]      pix_next_s;

    // Frame timing, advance request and saturating counter increment.
    always_comb begin
        frame_start_s = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
        active_s      = (bus.hcount_in < H_LIM) && (bus.vcount_in < V_LIM);
        // Button and timeout collapse into one request, so a coincidence yields a single pulse.
        advance_s     = (bus.btn_in && bus.arm_in) ||
                        (bus.auto_in && frame_start_s && (frame_cnt_r == TIMEOUT_LAST));
        cnt_inc_s     = (frame_cnt_r == CNT_SAT) ? frame_cnt_r : frame_cnt_r + CNT_W'(1);
    end

    // Layer compositing for the current screen and next output pixel.
    always_comb begin
        scr_mask_s = '0;
        for (int s = 0; s < NUM_SCREENS; s++) begin
            scr_mask_s = (screen_r == SCR_W'(s)) ? LAYER_MASK[s*NUM_LAYERS +: NUM_LAYERS] : scr_mask_s;
        end
        comp_pix_s = '0;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            comp_pix_s = comp_pix_s |
                         (bus.layer_pix_in[l*PIX_W +: PIX_W] & {PIX_W{scr_mask_s[l] & bus.layer_gate_in[l]}});
        end
        case (state_r)
            ST_SHOW:  pix_next_s = comp_pix_s;
            ST_TRANS: pix_next_s = BLANK_COLOR;
            ST_DONE:  pix_next_s = BLANK_COLOR;
            default:  pix_next_s = '0;
        endcase
        if (!active_s) begin
            pix_next_s = '0;
        end else begin
            pix_next_s = pix_next_s;
        end
    end

    // Sequencer state machine with registered pixel and status outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r       <= ST_SHOW;
            screen_r      <= '0;
            frame_cnt_r   <= '0;
            pixel_r       <= '0;
            screen_done_r <= 1'b0;
            seq_done_r    <= 1'b0;
        end else begin
            pixel_r       <= pix_next_s;
            screen_done_r <= 1'b0;
            case (state_r)
                ST_SHOW: begin
                    if (advance_s) begin
                        state_r       <= ST_TRANS;
                        frame_cnt_r   <= '0;
                        screen_done_r <= 1'b1;
                    end else if (frame_start_s) begin
                        frame_cnt_r   <= cnt_inc_s;
                    end
                end
                ST_TRANS: begin
                    if (frame_start_s && (frame_cnt_r == TRANS_LAST)) begin
                        frame_cnt_r <= '0;
                        if (screen_r == LAST_SCREEN) begin
                            state_r    <= ST_DONE;
                            seq_done_r <= 1'b1;
                        end else begin
                            state_r    <= ST_SHOW;
                            screen_r   <= screen_r + SCR_W'(1);
                        end
                    end else if (frame_start_s) begin
                        frame_cnt_r <= cnt_inc_s;
                    end
                end
                ST_DONE: begin
                    if (bus.restart_in) begin
                        state_r     <= ST_SHOW;
                        screen_r    <= '0;
                        frame_cnt_r <= '0;
                        seq_done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_SHOW;
                    screen_r    <= '0;
                    frame_cnt_r <= '0;
                    seq_done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pixel_out       = pixel_r;
    assign bus.screen_out      = screen_r;
    assign bus.screen_done_out = screen_done_r;
    assign bus.seq_done_out    = seq_done_r;
endmodule

// File: doc/screen_sequencer.md
SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 SHALL have parameter NUM_SCREENS, default 4, number of screens in the sequence (2..16).
REQ-002 SHALL have parameter NUM_LAYERS, default 3, number of sprite layers composited (1..8).
REQ-003 SHALL have parameter PIX_W, default 12, pixel width (RGB444).
REQ-004 SHALL have parameter LAYER_MASK, default all ones, width NUM_SCREENS*NUM_LAYERS; bit s*NUM_LAYERS+l enables layer l on screen s.
REQ-005 SHALL have parameter TIMEOUT_FRAMES, default 300, frames before auto-advance (>=1).
REQ-006 SHALL have parameter TRANS_FRAMES, default 2, frames of blank between screens (>=1).
REQ-007 SHALL have parameter BLANK_COLOR, default 12'hFFF, transition/done fill colour.
REQ-008 SHALL have parameters H_ACTIVE, default 1024, and V_ACTIVE, default 768.
REQ-009 clk_in  input  1  pixel clock; one clock only.
REQ-010 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-011 hcount_in  input  11  horizontal pixel count.
REQ-012 vcount_in  input  10  vertical line count.
REQ-013 layer_pix_in  input  NUM_LAYERS*PIX_W  sprite pixels, layer l at bits [l*PIX_W +: PIX_W].
REQ-014 layer_gate_in  input  NUM_LAYERS  run-time per-layer enable, ANDed with LAYER_MASK.
REQ-015 arm_in  input  1  level; button advance permitted only while high.
REQ-016 btn_in  input  1  single-cycle debounced press pulse.
REQ-017 auto_in  input  1  level; enables timeout auto-advance.
REQ-018 restart_in  input  1  single-cycle pulse; restarts sequence from DONE.
REQ-019 pixel_out  output  PIX_W  registered composited pixel.
REQ-020 screen_out  output  clog2(NUM_SCREENS)  current screen index.
REQ-021 screen_done_out  output  1  one-cycle pulse on every advance.
REQ-022 seq_done_out  output  1  level, high in DONE.

Function
REQ-023 SHALL implement states SHOW, TRANSITION, DONE.
REQ-024 frame_start SHALL be the cycle with hcount_in==0 and vcount_in==0.
REQ-025 A frame counter SHALL increment on each frame_start in SHOW and TRANSITION, clearing to 0 on every state entry.
REQ-026 SHOW: advance when (btn_in && arm_in) or (auto_in && frame_start && frame counter == TIMEOUT_FRAMES-1).
REQ-027 Button and timeout in the same cycle SHALL cause exactly one advance and one screen_done_out pulse.
REQ-028 On advance: screen_done_out high for exactly the next cycle; state -> TRANSITION.
REQ-029 TRANSITION: on frame_start with frame counter == TRANS_FRAMES-1, go to DONE if screen_out==NUM_SCREENS-1, else screen_out+1 and SHOW.
REQ-030 btn_in and timeout SHALL be ignored in TRANSITION and DONE.
REQ-031 DONE: seq_done_out=1; restart_in -> SHOW with screen_out=0, frame counter 0; restart_in ignored in other states.
REQ-032 Toggling auto_in low in SHOW SHALL not clear the frame counter; it only suppresses the timeout advance.
REQ-033 pixel_out, latency 1 cycle: in SHOW, bitwise OR of layers with LAYER_MASK bit and layer_gate_in bit set for the current screen; zero if none enabled.
REQ-034 pixel_out SHALL be BLANK_COLOR in TRANSITION and DONE.
REQ-035 pixel_out SHALL be 0 when hcount_in>=H_ACTIVE or vcount_in>=V_ACTIVE, in every state.
REQ-036 State and screen changes SHALL take effect for pixel_out from the cycle after the transition.
REQ-037 Frame counter SHALL be wide enough for max(TIMEOUT_FRAMES, TRANS_FRAMES) and saturate, never wrap.

Reset
REQ-038 rst_n_in low SHALL immediately force: state SHOW, screen_out 0, frame counter 0, pixel_out 0, screen_done_out 0, seq_done_out 0.
REQ-039 Reset asserted mid-TRANSITION or in DONE SHALL return to SHOW screen 0 with no screen_done_out pulse.
REQ-040 First advance after deassertion SHALL need a fresh btn_in or a full TIMEOUT_FRAMES count.

Verification
REQ-041 Layers 12'h00F/12'h0F0/12'hF00, all enabled, arm_in=1, hcount 100 vcount 50 -> pixel_out 12'hFFF one cycle later; layer_gate_in=3'b001 -> 12'h00F.
REQ-042 btn_in with arm_in=0 -> no advance; with arm_in=1 -> screen_done_out pulse, BLANK_COLOR for TRANS_FRAMES=2 frames, screen_out 0->1.
REQ-043 auto_in=1, TIMEOUT_FRAMES=3, no button -> advance on 3rd frame_start; btn_in on that same cycle -> single pulse.
REQ-044 NUM_SCREENS=4, four advances -> seq_done_out=1, pixel_out BLANK_COLOR; btn_in ignored; restart_in -> screen_out 0, SHOW.
REQ-045 rst_n_in pulsed low mid-TRANSITION, asynchronous to clk_in -> outputs zero immediately, SHOW screen 0 after release.
REQ-046 hcount_in=1100 -> pixel_out 0 in SHOW and in DONE.
